hack_dmux4_rr_arbiter: RTL and testbench
========================================

// Module: hack_dmux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4-way demultiplexed resource among 4 requesters.
//  It drives sel[1:0] into hack_dmux4_way (and the matching mux4 return path).
//  It drives a valid strobe that becomes the dmux 'in' bit.
//  It bounds how long one requester may own the path, and inserts a dead cycle between owners.
// PARAMETERS
//  MAX_HOLD  16  max consecutive grant cycles per ownership; legal range 1..2**CNT_W
//  CNT_W     4   width of hold counter; must hold MAX_HOLD-1
// PORTS
//  clk      in   1  single clock, rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  req      in   4  level requests, bit i = requester i; held high while it wants the path
//  grant    out  4  one-hot owner; 0000 when no owner
//  sel      out  2  binary index of current/last owner; feeds dmux/mux select
//  valid    out  1  high iff grant!=0; drives dmux 'in'
//  timeout  out  1  one-cycle pulse when an owner is preempted at MAX_HOLD
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous, immediate):
//   - outputs: grant=0000, sel=00, valid=0, timeout=0
//   - internal: state=IDLE, ptr=0, hold_cnt=0
//  State IDLE (grant=0000, valid=0):
//   - if req!=0: pick first set bit scanning ptr, ptr+1, ... (mod 4).
//   - next edge: state=OWN, grant=onehot(winner), sel=winner, hold_cnt=0.
//   - latency is 1 cycle from req sampled high to grant high.
//   - if req==0: stay in IDLE; sel holds its last value.
//  State OWN (valid=1), evaluated each edge on req[sel]:
//   - release: req[sel]==0 -> IDLE, grant=0000, ptr=sel+1 (mod 4), timeout=0.
//   - preempt: req[sel]==1 and hold_cnt==MAX_HOLD-1 -> IDLE, grant=0000, ptr=sel+1,
//     timeout=1 for exactly one cycle.
//   - otherwise: hold_cnt++, grant and sel unchanged.
//   - req changes on non-owner bits never affect the current owner.
//  Dead cycle: each handover passes through one IDLE cycle with grant=0000.
//   - no two grant bits are ever high together, including across cycles.
//   - sel changes only on the IDLE->OWN edge.
//  Boundaries:
//   - release coincident with hold limit: counts as release; timeout stays 0.
//   - MAX_HOLD=1: every ownership lasts exactly 1 cycle; a held req times out every grant.
//   - ptr wrap: 3+1 -> 0.
//   - all-ones req with each requester holding: order is 0,1,2,3,0,...
//   - reset mid-OWN: grant drops in the same cycle rst_n falls; after release arbitration
//     restarts from ptr=0.
//   - timeout is registered: it is high during the first IDLE cycle after preemption only.
//  Ownership period: an owner holds grant for at most MAX_HOLD cycles. With all 4
//   requesters busy, a requester waits at most 3*(MAX_HOLD+1)+1 cycles between grants.
// TESTING
//  1 rst_n=0 with req=1111, mid-OWN -> grant=0000, sel=00, valid=0, timeout=0 with no clk edge.
//  2 MAX_HOLD=4, req=1111 held -> grant 0001 x4, timeout pulse + 1 idle cycle,
//    then 0010 x4, 0100 x4, 1000 x4, 0001 x4.
//  3 req=0100 high for 1 cycle from IDLE -> next cycle grant=0100, sel=10, valid=1;
//    following cycle grant=0000, no timeout.
//  4 MAX_HOLD=4, owner 1 drops req exactly at hold_cnt=3 -> IDLE, timeout stays 0, ptr=2.
//  5 owner 2 releases, then req=0101 -> grant=0001 (ptr=3 scans 3,0); then 0100 after 0 releases.
//  6 Invariant checks every cycle: $onehot0(grant); valid==|grant; sel stable while valid;
//    a dead cycle between different owners.

Source files
------------

// File: rtl/hack_dmux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// hack_dmux4_rr_arbiter
//
// Round-robin arbiter that shares one 4-way demultiplexed resource (and its
// mux4 return path) among four level-sensitive requesters.
//
// An owner keeps the path while it holds its request, for at most MAX_HOLD
// consecutive cycles. When it reaches that limit it is preempted. Every
// handover goes through one IDLE cycle with no grant, so two owners never
// drive the shared path in back-to-back cycles.
//
// Parameters
//   MAX_HOLD : maximum consecutive grant cycles per ownership (1..2**CNT_W)
//   CNT_W    : width of the hold counter; must be able to hold MAX_HOLD-1
//
// Ports
//   clk     : single clock, rising edge
//   rst_n   : asynchronous, active-low reset
//   req     : level requests, bit i belongs to requester i
//   grant   : one-hot owner, 0000 when the path is free
//   sel     : binary index of the current/last owner (dmux/mux select)
//   valid   : high iff grant != 0; drives the dmux data-in bit
//   timeout : one-cycle pulse in the first IDLE cycle after a preemption
// ---------------------------------------------------------------------------
module hack_dmux4_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // hold_cnt counts completed grant cycles minus one; at this value the
    // owner has used its full allowance.
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

    state_t           state_reg,    state_next;
    logic [1:0]       ptr_reg,      ptr_next;
    logic [1:0]       sel_reg,      sel_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             timeout_reg,  timeout_next;

    logic [1:0]       winner;
    logic [1:0]       scan_idx;

    // -----------------------------------------------------------------------
    // Round-robin pick: scan ptr, ptr+1, ptr+2, ptr+3 (mod 4). Walking the
    // offsets from farthest to nearest lets the nearest set bit overwrite,
    // so the last assignment is the highest-priority requester.
    // -----------------------------------------------------------------------
    always_comb begin
        winner   = ptr_reg;
        scan_idx = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_reg + 2'(k);
            if (req[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        sel_next      = sel_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // sel only moves here, on the IDLE->OWN edge; otherwise it
                // keeps pointing at the last owner.
                if (|req) begin
                    state_next    = OWN;
                    sel_next      = winner;
                    hold_cnt_next = '0;
                end
            end

            OWN: begin
                // Only the owner's own request bit matters while owning.
                // A release on the limit cycle is still a release, so the
                // release test comes before the limit test.
                if (!req[sel_reg]) begin
                    state_next = IDLE;
                    ptr_next   = sel_reg + 2'd1;
                end else if (hold_cnt_reg == HOLD_LIMIT) begin
                    state_next   = IDLE;
                    ptr_next     = sel_reg + 2'd1;
                    timeout_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= 2'd0;
            sel_reg      <= 2'd0;
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            sel_reg      <= sel_next;
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. grant is decoded straight from registered state so it drops
    // in the same cycle that the asynchronous reset lands.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_grant
            assign grant[gi] = (state_reg == OWN) && (sel_reg == 2'(gi));
        end
    endgenerate

    assign valid   = (state_reg == OWN);
    assign sel     = sel_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_hack_dmux4_rr_arbiter.sv
module tb_hack_dmux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;

    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       timeout;

    logic [3:0] grant1;
    logic [1:0] sel1;
    logic       valid1;
    logic       timeout1;

    int checks;
    int fails;

    logic [3:0] prev_grant;
    logic [1:0] prev_sel;
    logic       prev_valid;

    hack_dmux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .grant   (grant),
        .sel     (sel),
        .valid   (valid),
        .timeout (timeout)
    );

    hack_dmux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .grant   (grant1),
        .sel     (sel1),
        .valid   (valid1),
        .timeout (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle invariants on the MAX_HOLD=4 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_grant <= 4'b0000;
            prev_sel   <= 2'b00;
            prev_valid <= 1'b0;
        end else begin
            checks = checks + 1;
            if (!$onehot0(grant)) begin
                fails = fails + 1;
                $display("FAIL inv_onehot0: grant=%b", grant);
            end
            checks = checks + 1;
            if (valid !== (|grant)) begin
                fails = fails + 1;
                $display("FAIL inv_valid: valid=%b required=%b", valid, |grant);
            end
            checks = checks + 1;
            if (valid && prev_valid && (sel !== prev_sel)) begin
                fails = fails + 1;
                $display("FAIL inv_sel_stable: sel=%0d previous=%0d", sel, prev_sel);
            end
            checks = checks + 1;
            if ((prev_grant != 4'b0000) && (grant != 4'b0000) && (grant !== prev_grant)) begin
                fails = fails + 1;
                $display("FAIL inv_dead_cycle: grant=%b previous=%b", grant, prev_grant);
            end
            prev_grant <= grant;
            prev_sel   <= sel;
            prev_valid <= valid;
        end
    end

    // Advance one clock; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (grant !== 4'b0000 || sel !== 2'b00 || valid !== 1'b0 || timeout !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL reset_state: grant=%b sel=%b valid=%b timeout=%b required 0000/00/0/0",
                     grant, sel, valid, timeout);
        end
        // Take ownership as requester 2, then pull reset between clock edges.
        rst_n = 1'b1;
        req   = 4'b0100;
        step();
        checks = checks + 1;
        if (grant !== 4'b0100 || sel !== 2'b10) begin
            fails = fails + 1;
            $display("FAIL reset_pre_own: grant=%b sel=%b required 0100/10", grant, sel);
        end
        req = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if (grant !== 4'b0000 || sel !== 2'b00 || valid !== 1'b0 || timeout !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL reset_async: grant=%b sel=%b valid=%b timeout=%b required 0000/00/0/0",
                     grant, sel, valid, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks = checks + 1;
        if (grant !== 4'b0001) begin
            fails = fails + 1;
            $display("FAIL reset_restart_ptr0: grant=%b required 0001", grant);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic       exp_t;
        do_reset();
        req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 5; c++) begin
                step();
                if (c < 4) begin
                    exp_g = 4'b0001 << (o % 4);
                    exp_t = 1'b0;
                end else begin
                    exp_g = 4'b0000;
                    exp_t = 1'b1;
                end
                checks = checks + 1;
                if (grant !== exp_g || timeout !== exp_t) begin
                    fails = fails + 1;
                    $display("FAIL rr_all_ones owner%0d cycle%0d: grant=%b timeout=%b required %b/%b",
                             o, c, grant, timeout, exp_g, exp_t);
                end
            end
        end
    endtask

    task automatic test_single_pulse();
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b0000;
        checks = checks + 1;
        if (grant !== 4'b0100 || sel !== 2'b10 || valid !== 1'b1 || timeout !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL single_grant: grant=%b sel=%b valid=%b timeout=%b required 0100/10/1/0",
                     grant, sel, valid, timeout);
        end
        step();
        checks = checks + 1;
        if (grant !== 4'b0000 || valid !== 1'b0 || timeout !== 1'b0 || sel !== 2'b10) begin
            fails = fails + 1;
            $display("FAIL single_release: grant=%b valid=%b timeout=%b sel=%b required 0000/0/0/10",
                     grant, valid, timeout, sel);
        end
    endtask

    task automatic test_release_at_limit();
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            step();
            checks = checks + 1;
            if (grant !== 4'b0010 || timeout !== 1'b0) begin
                fails = fails + 1;
                $display("FAIL limit_hold cycle%0d: grant=%b timeout=%b required 0010/0",
                         c, grant, timeout);
            end
        end
        req = 4'b0000;
        step();
        checks = checks + 1;
        if (grant !== 4'b0000 || timeout !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL limit_release: grant=%b timeout=%b required 0000/0", grant, timeout);
        end
        req = 4'b1111;
        step();
        checks = checks + 1;
        if (grant !== 4'b0100 || timeout !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL limit_ptr2: grant=%b timeout=%b required 0100/0", grant, timeout);
        end
    endtask

    // Continues from owner 2 left by test_release_at_limit.
    task automatic test_ptr_scan();
        req = 4'b0000;
        step();
        checks = checks + 1;
        if (grant !== 4'b0000) begin
            fails = fails + 1;
            $display("FAIL scan_release2: grant=%b required 0000", grant);
        end
        req = 4'b0101;
        step();
        checks = checks + 1;
        if (grant !== 4'b0001 || sel !== 2'b00) begin
            fails = fails + 1;
            $display("FAIL scan_wrap_to0: grant=%b sel=%b required 0001/00", grant, sel);
        end
        req = 4'b0100;
        step();
        checks = checks + 1;
        if (grant !== 4'b0000) begin
            fails = fails + 1;
            $display("FAIL scan_release0: grant=%b required 0000", grant);
        end
        step();
        checks = checks + 1;
        if (grant !== 4'b0100 || sel !== 2'b10) begin
            fails = fails + 1;
            $display("FAIL scan_next2: grant=%b sel=%b required 0100/10", grant, sel);
        end
    endtask

    task automatic test_max_hold_one();
        logic [3:0] exp_g;
        logic       exp_t;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            if ((i % 2) == 0) begin
                exp_g = 4'b0001 << (i / 2);
                exp_t = 1'b0;
            end else begin
                exp_g = 4'b0000;
                exp_t = 1'b1;
            end
            checks = checks + 1;
            if (grant1 !== exp_g || timeout1 !== exp_t || valid1 !== (exp_g != 4'b0000)) begin
                fails = fails + 1;
                $display("FAIL hold1 cycle%0d: grant=%b timeout=%b valid=%b required %b/%b",
                         i, grant1, timeout1, valid1, exp_g, exp_t);
            end
        end
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst_n      = 1'b0;
        req        = 4'b0000;
        prev_grant = 4'b0000;
        prev_sel   = 2'b00;
        prev_valid = 1'b0;

        test_reset();
        test_round_robin();
        test_single_pulse();
        test_release_at_limit();
        test_ptr_scan();
        test_max_hold_one();

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
